// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and abort data word for the MMIO arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_ABORT} arb_state_t;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/wb_mmio_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching from last+1 upward.
module rr_pick #(
  parameter int N_MASTER = 2,
  localparam int IW = $clog2(N_MASTER)
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [IW-1:0]       last,
  output logic [N_MASTER-1:0] gnt,
  output logic [IW-1:0]       idx
);
  logic [IW-1:0] j;
  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int i = N_MASTER; i > 0; i--) begin
      j = IW'((int'(last) + i) % N_MASTER);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/wb_mmio_arbiter.sv
// wb_mmio_arbiter: round-robin Wishbone classic arbiter with a bus watchdog for the MMIO slave bus.
`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module wb_mmio_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTER = 2,
  parameter int ADDR_W = `MMIO_ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IW = $clog2(N_MASTER),
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic [N_MASTER-1:0]        M_CYC_I,
  input  logic [N_MASTER-1:0]        M_STB_I,
  input  logic [N_MASTER-1:0]        M_WE_I,
  input  logic [N_MASTER*ADDR_W-1:0] M_ADDR_I,
  input  logic [N_MASTER*DATA_W-1:0] M_DAT_I,
  output logic [DATA_W-1:0]          M_DAT_O,
  output logic [N_MASTER-1:0]        M_ACK_O,
  output logic                       CYC_O,
  output logic                       STB_O,
  output logic                       WE_O,
  output logic [ADDR_W-1:0]          ADDR_O,
  output logic [DATA_W-1:0]          DAT_O,
  input  logic [DATA_W-1:0]          DAT_I,
  input  logic                       ACK_I,
  output logic [N_MASTER-1:0]        grant_o,
  output logic                       timeout_o,
  output logic [IW-1:0]              timeout_master_o,
  input  logic                       clr_timeout_i
);
  arb_state_t state, state_n;
  logic [N_MASTER-1:0] grant_n, pick_gnt;
  logic [IW-1:0] last, last_n, pick_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic busy, abort, stall, expire;
  logic [ADDR_W-1:0] addr_a [N_MASTER];
  logic [DATA_W-1:0] dat_a [N_MASTER];
  for (genvar g = 0; g < N_MASTER; g++) begin : g_unpack
    assign addr_a[g] = M_ADDR_I[g*ADDR_W +: ADDR_W];
    assign dat_a[g] = M_DAT_I[g*DATA_W +: DATA_W];
  end
  rr_pick #(.N_MASTER(N_MASTER)) u_pick (
    .req(M_CYC_I),
    .last(last),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  // While busy, last always holds the granted master's index.
  assign busy = state == ARB_BUSY;
  assign abort = state == ARB_ABORT;
  assign CYC_O = busy & M_CYC_I[last];
  assign STB_O = busy & M_STB_I[last];
  assign WE_O = busy & M_WE_I[last];
  assign ADDR_O = busy ? addr_a[last] : '0;
  assign DAT_O = busy ? dat_a[last] : '0;
  assign M_ACK_O = busy ? grant_o & {N_MASTER{ACK_I}} : abort ? grant_o : '0;
  assign M_DAT_O = busy ? DAT_I : abort ? DATA_W'(TIMEOUT_DATA) : '0;
  assign stall = STB_O & ~ACK_I;
  assign expire = TIMEOUT_CYCLES != 0 && stall && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    grant_n = grant_o;
    last_n = last;
    cnt_n = cnt;
    case (state)
      ARB_IDLE: if (|M_CYC_I) begin
        state_n = ARB_BUSY;
        grant_n = pick_gnt;
        last_n = pick_idx;
        cnt_n = '0;
      end
      ARB_BUSY: if (!M_CYC_I[last]) begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end else if (expire) state_n = ARB_ABORT;
      else cnt_n = ACK_I ? '0 : (stall && cnt != '1) ? cnt + CW'(1) : cnt;
      default: begin
        state_n = ARB_BUSY;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ARB_IDLE;
      grant_o <= '0;
      last <= IW'(N_MASTER - 1);
      cnt <= '0;
      timeout_o <= 1'b0;
      timeout_master_o <= '0;
    end else begin
      state <= state_n;
      grant_o <= grant_n;
      last <= last_n;
      cnt <= cnt_n;
      timeout_o <= abort | (timeout_o & ~clr_timeout_i);
      timeout_master_o <= abort ? last : timeout_master_o;
    end
  end
endmodule

// File: tb/tb_wb_mmio_arbiter.sv
// tb_wb_mmio_arbiter: directed self-checking bench for the MMIO arbiter with an 8-cycle watchdog.
module tb_wb_mmio_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  logic clk = 0;
  logic rst = 1;
  logic [1:0] m_cyc = 0, m_stb = 0, m_we = 0;
  logic [2*AW-1:0] m_addr = 0;
  logic [2*DW-1:0] m_dat = 0;
  logic [DW-1:0] m_dat_o, dat_o, dat_i = 0;
  logic [1:0] m_ack, grant;
  logic cyc_o, stb_o, we_o, ack_i = 0, tmo, clr = 0;
  logic [AW-1:0] addr_o;
  logic [0:0] tmo_m;
  int checks = 0, errors = 0;
  logic [1:0] exp_g;

  always #5 clk = ~clk;

  wb_mmio_arbiter #(.N_MASTER(2), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .CLK_I(clk), .RST_I(rst),
    .M_CYC_I(m_cyc), .M_STB_I(m_stb), .M_WE_I(m_we), .M_ADDR_I(m_addr), .M_DAT_I(m_dat),
    .M_DAT_O(m_dat_o), .M_ACK_O(m_ack),
    .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ADDR_O(addr_o), .DAT_O(dat_o),
    .DAT_I(dat_i), .ACK_I(ack_i),
    .grant_o(grant), .timeout_o(tmo), .timeout_master_o(tmo_m), .clr_timeout_i(clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_tmo_m", tmo_m, 0);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_mdat", m_dat_o, 0);
    chk("rst_addr", addr_o, 0);
    // stray ack while idle
    ack_i = 1;
    dat_i = 32'h1234_5678;
    #1;
    chk("stray_ack", m_ack, 0);
    chk("stray_dat", m_dat_o, 0);
    tick();
    ack_i = 0;
    #1;
    chk("stray_grant", grant, 0);
    // single master write with two wait cycles
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_addr = {16'h0020, 16'h0010};
    m_dat = {32'h0000_00AA, 32'h0000_0055};
    #1;
    chk("single_cyc_t0", cyc_o, 0);
    tick();
    #1;
    chk("single_stb", stb_o, 1);
    chk("single_we", we_o, 1);
    chk("single_addr", addr_o, 16'h0010);
    chk("single_dat", dat_o, 32'h55);
    chk("single_grant", grant, 2'b01);
    chk("single_noack", m_ack, 0);
    tick();
    tick();
    ack_i = 1;
    dat_i = 32'hCAFE_0001;
    #1;
    chk("single_ack", m_ack, 2'b01);
    chk("single_mdat", m_dat_o, 32'hCAFE_0001);
    tick();
    ack_i = 0; m_cyc = 0; m_stb = 0; m_we = 0;
    tick();
    #1;
    chk("single_release", grant, 0);
    // simultaneous requests from reset
    rst = 1;
    tick();
    rst = 0;
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      ack_i = 1;
      dat_i = 32'h1000 + k;
      #1;
      chk("rr_grant", grant, exp_g);
      chk("rr_ack", m_ack, exp_g);
      chk("rr_addr", addr_o, exp_g[0] ? 16'h0010 : 16'h0020);
      chk("rr_mdat", m_dat_o, 32'h1000 + k);
      tick();
      ack_i = 0;
      m_cyc = ~exp_g; m_stb = ~exp_g;
      #1;
      chk("rr_drop_ack", m_ack, 0);
      tick();
      #1;
      chk("rr_gap", grant, 0);
      m_cyc = (k == 5) ? 2'b00 : 2'b11;
      m_stb = m_cyc;
    end
    // master 1 read that the slave never acknowledges
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 0;
    tick();
    #1;
    chk("to_grant", grant, 2'b10);
    chk("to_cyc", cyc_o, 1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      #1;
      chk("to_stall_ack", m_ack, 0);
    end
    tick();
    #1;
    chk("to_abort_ack", m_ack, 2'b10);
    chk("to_abort_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("to_abort_cyc", cyc_o, 0);
    chk("to_abort_stb", stb_o, 0);
    tick();
    #1;
    chk("to_flag", tmo, 1);
    chk("to_master", tmo_m, 1);
    chk("to_post_ack", m_ack, 0);
    chk("to_post_grant", grant, 2'b10);
    m_cyc = 0; m_stb = 0;
    tick();
    #1;
    chk("to_release", grant, 0);
    chk("to_sticky", tmo, 1);
    clr = 1;
    tick();
    clr = 0;
    #1;
    chk("clr_flag", tmo, 0);
    // clear requested during an abort: set wins
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    for (int i = 2; i <= 9; i++) tick();
    clr = 1;
    #1;
    chk("clr_abort_ack", m_ack, 2'b01);
    tick();
    clr = 0;
    #1;
    chk("clr_set_wins", tmo, 1);
    chk("clr_master", tmo_m, 0);
    m_cyc = 0; m_stb = 0;
    tick();
    tick();
    // reset while a stalled cycle is in flight
    m_cyc = 2'b10; m_stb = 2'b10;
    tick();
    #1;
    chk("mid_busy", cyc_o, 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("mid_cyc", cyc_o, 0);
    chk("mid_grant", grant, 0);
    chk("mid_ack", m_ack, 0);
    chk("mid_tmo", tmo, 0);
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    #1;
    chk("mid_first", grant, 2'b01);
    m_cyc = 0; m_stb = 0;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
